// File: rtl/sc2_blitter_pkg.sv
// sc2_blitter shared types: FSM states, register map, ctrl bits.
// Also the width/height register encode helper.
package sc2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_HALT,
    SRC,
    DST
  } state_t;

  localparam logic [2:0] RS_CTRL   = 3'd0;
  localparam logic [2:0] RS_CONST  = 3'd1;
  localparam logic [2:0] RS_SRC_HI = 3'd2;
  localparam logic [2:0] RS_SRC_LO = 3'd3;
  localparam logic [2:0] RS_DST_HI = 3'd4;
  localparam logic [2:0] RS_DST_LO = 3'd5;
  localparam logic [2:0] RS_WIDTH  = 3'd6;
  localparam logic [2:0] RS_HEIGHT = 3'd7;

  localparam int CB_SUP_UPPER = 7;
  localparam int CB_SUP_LOWER = 6;
  localparam int CB_SHIFT_R   = 5;
  localparam int CB_CONST_SUB = 4;
  localparam int CB_ZERO_SUP  = 3;
  localparam int CB_SYNC_E    = 2;
  localparam int CB_SPAN_DST  = 1;
  localparam int CB_SPAN_SRC  = 0;

  function automatic logic [8:0] size_reg(
    input logic [7:0] d,
    input logic [7:0] x
  );
    return {1'b0, d ^ x};
  endfunction

endpackage

// File: rtl/sc2_blitter_if.sv
// Blitter CPU-register and shared-bus signal bundle.
// master = blitter side, slave = CPU / bus mux side.
interface sc2_blitter_if #(
  parameter int ADDR_W = 16
);
  logic              e_sync;
  logic              reg_cs;
  logic [2:0]        rs;
  logic [7:0]        reg_data_in;
  logic              halt;
  logic              halt_ack;
  logic              blt_ack;
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] blt_address_out;
  logic [7:0]        blt_data_in;
  logic [7:0]        blt_data_out;
  logic              en_upper;
  logic              en_lower;
  logic              blt_done;

  modport master (
    input  e_sync, reg_cs, rs, reg_data_in,
    input  halt_ack, blt_ack, blt_data_in,
    output halt, read, write,
    output blt_address_out, blt_data_out,
    output en_upper, en_lower, blt_done
  );

  modport slave (
    output e_sync, reg_cs, rs, reg_data_in,
    output halt_ack, blt_ack, blt_data_in,
    input  halt, read, write,
    input  blt_address_out, blt_data_out,
    input  en_upper, en_lower, blt_done
  );
endinterface

// File: rtl/sc2_blitter_pixel_path.sv
// Pixel path: nibble shift, constant substitute, write enables.
// In: src byte, prev_nib, ctrl bits, constant, state. Out: data, en_upper/lower.
module blt_pixel_path
  import sc2_pkg::*;
(
  input  logic [7:0] i_src,
  input  logic [3:0] i_prev_nib,
  input  logic       i_sup_upper,
  input  logic       i_sup_lower,
  input  logic       i_shift_right,
  input  logic       i_const_sub,
  input  logic       i_zero_sup,
  input  logic [7:0] i_const,
  input  state_t     i_state,
  output logic [7:0] o_data,
  output logic       o_en_upper,
  output logic       o_en_lower
);

  logic [7:0] w_pix;
  logic       w_z_hi;
  logic       w_z_lo;
  logic       w_dst;

  assign w_pix = i_shift_right ?
    {i_prev_nib, i_src[7:4]} : i_src;

  assign o_data = i_const_sub ? i_const : w_pix;

  // Zero test looks at the pixel even when the constant is written.
  assign w_z_hi = i_zero_sup & (w_pix[7:4] == 4'h0);
  assign w_z_lo = i_zero_sup & (w_pix[3:0] == 4'h0);
  assign w_dst  = (i_state == DST);

  assign o_en_upper = ~w_dst | ~(i_sup_upper | w_z_hi);
  assign o_en_lower = ~w_dst | ~(i_sup_lower | w_z_lo);

endmodule

// File: rtl/sc2_blitter.sv
// Williams SC1/SC2 pixel blitter: halts CPU, copies width x height src->dst.
// Ports: clk, reset_n, bus (sc2_blitter_if.master: regs, halt, bus, done).
module sc2_blitter
  import sc2_pkg::*;
#(
  parameter int         ADDR_W     = 16,
  parameter int         ROW_STRIDE = 256,
  parameter logic [7:0] SIZE_XOR   = 8'h04
) (
  input logic           clk,
  input logic           reset_n,
  sc2_blitter_if.master bus
);

  state_t            r_state;
  logic [7:0]        r_ctrl;
  logic [7:0]        r_const;
  logic [7:0]        r_src_byte;
  logic [15:0]       r_src_base;
  logic [15:0]       r_dst_base;
  logic [8:0]        r_width;
  logic [8:0]        r_height;
  logic [8:0]        r_x;
  logic [8:0]        r_y;
  logic [ADDR_W-1:0] r_src_addr;
  logic [ADDR_W-1:0] r_dst_addr;
  logic [3:0]        r_prev_nib;
  logic              r_halt;
  logic              r_done;

  logic              w_go;
  logic              w_ack;
  logic              w_row_end;
  logic              w_last;
  logic [8:0]        w_x_nxt;
  logic [8:0]        w_y_nxt;
  logic [ADDR_W-1:0] w_stride;
  logic [ADDR_W-1:0] w_one;
  logic [ADDR_W-1:0] w_src_nxt;
  logic [ADDR_W-1:0] w_dst_nxt;

  // With sync_e set the bus is only requested in E-sync clocks.
  assign w_go = ~r_ctrl[CB_SYNC_E] | bus.e_sync;
  assign bus.read  = (r_state == SRC) & w_go;
  assign bus.write = (r_state == DST) & w_go;
  assign w_ack = bus.blt_ack & (bus.read | bus.write);

  assign w_x_nxt   = r_x + 9'd1;
  assign w_y_nxt   = r_y + 9'd1;
  assign w_row_end = (w_x_nxt == r_width);
  assign w_last    = w_row_end & (w_y_nxt == r_height);

  assign w_stride = ADDR_W'(ROW_STRIDE);
  assign w_one    = ADDR_W'(1);

  // Span mode walks a column; a new row restarts at base + row.
  assign w_src_nxt = ~r_ctrl[CB_SPAN_SRC] ? r_src_addr + w_one :
    w_row_end ? ADDR_W'(r_src_base) + ADDR_W'(w_y_nxt) :
    r_src_addr + w_stride;
  assign w_dst_nxt = ~r_ctrl[CB_SPAN_DST] ? r_dst_addr + w_one :
    w_row_end ? ADDR_W'(r_dst_base) + ADDR_W'(w_y_nxt) :
    r_dst_addr + w_stride;

  assign bus.blt_address_out =
    (r_state == DST) ? r_dst_addr : r_src_addr;
  assign bus.halt     = r_halt;
  assign bus.blt_done = r_done;

  blt_pixel_path u_pix (
    .i_src         (r_src_byte),
    .i_prev_nib    (r_prev_nib),
    .i_sup_upper   (r_ctrl[CB_SUP_UPPER]),
    .i_sup_lower   (r_ctrl[CB_SUP_LOWER]),
    .i_shift_right (r_ctrl[CB_SHIFT_R]),
    .i_const_sub   (r_ctrl[CB_CONST_SUB]),
    .i_zero_sup    (r_ctrl[CB_ZERO_SUP]),
    .i_const       (r_const),
    .i_state       (r_state),
    .o_data        (bus.blt_data_out),
    .o_en_upper    (bus.en_upper),
    .o_en_lower    (bus.en_lower)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_ctrl     <= 8'h00;
      r_const    <= 8'hFF;
      r_src_byte <= 8'h00;
      r_src_base <= 16'h0000;
      r_dst_base <= 16'h0000;
      r_width    <= 9'd0;
      r_height   <= 9'd0;
      r_x        <= 9'd0;
      r_y        <= 9'd0;
      r_src_addr <= '0;
      r_dst_addr <= '0;
      r_prev_nib <= 4'h0;
      r_halt     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.reg_cs) begin
            unique case (bus.rs)
              RS_CTRL: begin
                r_ctrl <= bus.reg_data_in;
                if (r_width != 9'd0 &&
                    r_height != 9'd0) begin
                  r_state <= WAIT_HALT;
                  r_halt  <= 1'b1;
                end
              end
              RS_CONST:  r_const <= bus.reg_data_in;
              RS_SRC_HI: r_src_base[15:8] <= bus.reg_data_in;
              RS_SRC_LO: r_src_base[7:0] <= bus.reg_data_in;
              RS_DST_HI: r_dst_base[15:8] <= bus.reg_data_in;
              RS_DST_LO: r_dst_base[7:0] <= bus.reg_data_in;
              RS_WIDTH:
                r_width <= size_reg(bus.reg_data_in, SIZE_XOR);
              RS_HEIGHT:
                r_height <= size_reg(bus.reg_data_in, SIZE_XOR);
              default: ;
            endcase
          end
        end
        WAIT_HALT: begin
          if (bus.halt_ack) begin
            r_state    <= SRC;
            r_src_addr <= ADDR_W'(r_src_base);
            r_dst_addr <= ADDR_W'(r_dst_base);
            r_x        <= 9'd0;
            r_y        <= 9'd0;
            r_prev_nib <= 4'h0;
          end
        end
        SRC: begin
          if (w_ack) begin
            r_src_byte <= bus.blt_data_in;
            r_state    <= DST;
          end
        end
        DST: begin
          if (w_ack) begin
            r_src_addr <= w_src_nxt;
            r_dst_addr <= w_dst_nxt;
            if (w_row_end) begin
              r_x        <= 9'd0;
              r_y        <= w_y_nxt;
              r_prev_nib <= 4'h0;
            end else begin
              r_x        <= w_x_nxt;
              r_prev_nib <= r_src_byte[3:0];
            end
            if (w_last) begin
              r_state <= IDLE;
              r_halt  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= SRC;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sc2_blitter.sv
// Randomised bench for sc2_blitter against a transfer-list model.
// Memory model answers reads; every bus transaction is scored.
module tb_sc2_blitter;

  localparam logic [7:0] SX = 8'h04;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sc2_blitter_if #(.ADDR_W(16)) bif ();

  sc2_blitter #(
    .ADDR_W    (16),
    .ROW_STRIDE(256),
    .SIZE_XOR  (SX)
  ) dut (
    .clk    (clk),
    .reset_n(rst_n),
    .bus    (bif)
  );

  typedef struct {
    int         a;
    logic [7:0] d;
    logic       eu;
    logic       el;
  } wr_t;

  logic [7:0] mem [65536];
  int         rq[$];
  wr_t        wq[$];
  logic [7:0] wlog[$];
  int         alog[$];
  logic [1:0] elog[$];

  int n_vec = 0;
  int n_err = 0;
  int n_done = 0;
  int cyc = 0;
  int es_per = 0;
  bit ack_hold = 0;
  bit gate_chk = 0;
  bit mon_en = 1;
  bit pend_cs = 0;
  logic [2:0] pend_rs = 3'd0;
  logic [7:0] pend_d = 8'h00;

  logic [7:0] sh_ctrl, sh_const;
  int sh_src, sh_dst, sh_w, sh_h;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected transfer list straight from the row/column rules.
  function automatic void build();
    int sa, da, pa;
    logic [7:0] s, pix, t;
    logic [3:0] pn;
    wr_t w;
    rq.delete();
    wq.delete();
    for (int y = 0; y < sh_h; y++)
      for (int x = 0; x < sh_w; x++) begin
        sa = sh_ctrl[0] ? sh_src + y + x * 256 :
                          sh_src + y * sh_w + x;
        pa = sh_ctrl[0] ? sh_src + y + (x - 1) * 256 :
                          sh_src + y * sh_w + x - 1;
        da = sh_ctrl[1] ? sh_dst + y + x * 256 :
                          sh_dst + y * sh_w + x;
        sa = sa & 'hFFFF;
        pa = pa & 'hFFFF;
        da = da & 'hFFFF;
        s = mem[sa];
        t = mem[pa];
        pn = (x == 0) ? 4'h0 : t[3:0];
        pix = sh_ctrl[5] ? {pn, s[7:4]} : s;
        w.a = da;
        w.d = sh_ctrl[4] ? sh_const : pix;
        w.eu = !(sh_ctrl[7] || (sh_ctrl[3] && pix[7:4] == 4'h0));
        w.el = !(sh_ctrl[6] || (sh_ctrl[3] && pix[3:0] == 4'h0));
        rq.push_back(sa);
        wq.push_back(w);
      end
  endfunction

  task automatic step();
    wr_t w;
    @(negedge clk);
    cyc++;
    bif.e_sync = (es_per != 0) ? (cyc % es_per == 0) :
                 1'($urandom_range(0, 1));
    bif.blt_ack = ack_hold ? 1'b1 : ($urandom_range(0, 3) != 0);
    bif.halt_ack = bif.halt;
    bif.blt_data_in = mem[bif.blt_address_out];
    bif.reg_cs = pend_cs;
    bif.rs = pend_rs;
    bif.reg_data_in = pend_d;
    pend_cs = 0;
    #1;
    if (bif.blt_done) n_done++;
    if (!mon_en) return;
    if (gate_chk && (bif.read || bif.write))
      chk("esync_gate", 32'(bif.e_sync), 32'd1);
    if (bif.read && bif.blt_ack) begin
      chk("rd_expected", 32'(rq.size() > 0), 32'd1);
      if (rq.size() > 0)
        chk("rd_addr", 32'(bif.blt_address_out), rq.pop_front());
    end
    if (bif.write && bif.blt_ack) begin
      chk("wr_expected", 32'(wq.size() > 0), 32'd1);
      wlog.push_back(bif.blt_data_out);
      alog.push_back(int'(bif.blt_address_out));
      elog.push_back({bif.en_upper, bif.en_lower});
      if (wq.size() > 0) begin
        w = wq.pop_front();
        chk("wr_addr", 32'(bif.blt_address_out), w.a);
        chk("wr_data", 32'(bif.blt_data_out), 32'(w.d));
        chk("en_upper", 32'(bif.en_upper), 32'(w.eu));
        chk("en_lower", 32'(bif.en_lower), 32'(w.el));
      end
    end
  endtask

  task automatic wr_reg(input logic [2:0] r, input logic [7:0] d);
    case (r)
      3'd0: sh_ctrl = d;
      3'd1: sh_const = d;
      3'd2: sh_src = (int'(d) << 8) | (sh_src & 'hFF);
      3'd3: sh_src = (sh_src & 'hFF00) | int'(d);
      3'd4: sh_dst = (int'(d) << 8) | (sh_dst & 'hFF);
      3'd5: sh_dst = (sh_dst & 'hFF00) | int'(d);
      3'd6: sh_w = int'(d ^ SX);
      default: sh_h = int'(d ^ SX);
    endcase
    pend_cs = 1;
    pend_rs = r;
    pend_d = d;
    step();
  endtask

  task automatic run_xfer(input logic [7:0] ctrl, input bit inject);
    int d0, bud;
    bit inj;
    wlog.delete();
    alog.delete();
    elog.delete();
    gate_chk = ctrl[2];
    d0 = n_done;
    inj = 0;
    wr_reg(3'd0, ctrl);
    build();
    bud = 60 + sh_w * sh_h * 60;
    for (int i = 0; i < bud && n_done == d0; i++) begin
      if (inject && !inj && bif.write && wq.size() >= 2) begin
        pend_cs = 1;
        pend_rs = 3'($urandom_range(0, 7));
        pend_d = 8'($urandom);
        inj = 1;
      end
      step();
    end
    chk("done_cnt", n_done - d0, 32'd1);
    chk("halt_end", 32'(bif.halt), 32'd0);
    chk("rd_left", rq.size(), 32'd0);
    chk("wr_left", wq.size(), 32'd0);
    step();
    chk("done_pulse", 32'(bif.blt_done), 32'd0);
    gate_chk = 0;
  endtask

  task automatic run_zero(input logic [7:0] ctrl);
    int d0;
    bit saw;
    d0 = n_done;
    saw = 0;
    wr_reg(3'd0, ctrl);
    repeat (10) begin
      step();
      saw |= bif.halt;
    end
    chk("zero_halt", 32'(saw), 32'd0);
    chk("zero_done", n_done - d0, 32'd0);
  endtask

  task automatic reset_mid();
    int d0;
    wr_reg(3'd6, 8'd3 ^ SX);
    wr_reg(3'd7, 8'd3 ^ SX);
    wr_reg(3'd0, 8'h00);
    build();
    for (int i = 0; i < 100 && !bif.write; i++) step();
    chk("rst_in_dst", 32'(bif.write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_halt", 32'(bif.halt), 32'd0);
    chk("rst_read", 32'(bif.read), 32'd0);
    chk("rst_write", 32'(bif.write), 32'd0);
    mon_en = 0;
    d0 = n_done;
    repeat (3) step();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step();
    chk("rst_no_done", n_done - d0, 32'd0);
    chk("rst_halt2", 32'(bif.halt), 32'd0);
    rq.delete();
    wq.delete();
    mon_en = 1;
    sh_ctrl = 8'h00;
    sh_const = 8'hFF;
    sh_src = 0;
    sh_dst = 0;
    sh_w = 0;
    sh_h = 0;
  endtask

  initial begin
    logic [7:0] ctrl, m;
    int ws, hs;
    rst_n = 1'b0;
    bif.e_sync = 0;
    bif.reg_cs = 0;
    bif.rs = 0;
    bif.reg_data_in = 0;
    bif.halt_ack = 0;
    bif.blt_ack = 0;
    bif.blt_data_in = 0;
    sh_ctrl = 8'h00;
    sh_const = 8'hFF;
    sh_src = 0;
    sh_dst = 0;
    sh_w = 0;
    sh_h = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    repeat (3) @(negedge clk);
    #1;
    chk("rst_halt0", 32'(bif.halt), 32'd0);
    chk("rst_read0", 32'(bif.read), 32'd0);
    chk("rst_write0", 32'(bif.write), 32'd0);
    chk("rst_done0", 32'(bif.blt_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_zero(8'h00);

    wr_reg(3'd2, 8'h10);
    wr_reg(3'd3, 8'h00);
    wr_reg(3'd4, 8'h20);
    wr_reg(3'd5, 8'h00);
    wr_reg(3'd6, 8'd2 ^ SX);
    wr_reg(3'd7, 8'd1 ^ SX);
    run_xfer(8'h00, 0);
    chk("t1_a0", alog[0], 32'h2000);
    chk("t1_a1", alog[1], 32'h2001);

    wr_reg(3'd7, 8'd2 ^ SX);
    run_xfer(8'h02, 0);
    chk("t2_a1", alog[1], 32'h2100);
    chk("t2_a2", alog[2], 32'h2001);
    chk("t2_a3", alog[3], 32'h2101);

    mem[16'h1000] = 8'hAB;
    mem[16'h1001] = 8'hCD;
    m = mem[16'h1002];
    run_xfer(8'h20, 0);
    chk("t3_w0", 32'(wlog[0]), 32'h0A);
    chk("t3_w1", 32'(wlog[1]), 32'hBC);
    chk("t3_row2", 32'(wlog[2]), 32'({4'h0, m[7:4]}));

    mem[16'h1000] = 8'h0F;
    wr_reg(3'd1, 8'h55);
    wr_reg(3'd6, 8'd1 ^ SX);
    wr_reg(3'd7, 8'd1 ^ SX);
    run_xfer(8'h18, 0);
    chk("t4_data", 32'(wlog[0]), 32'h55);
    chk("t4_en", 32'(elog[0]), 32'b01);

    es_per = 4;
    ack_hold = 1;
    wr_reg(3'd6, 8'd2 ^ SX);
    run_xfer(8'h04, 0);
    es_per = 0;
    ack_hold = 0;

    wr_reg(3'd6, 8'd4 ^ SX);
    wr_reg(3'd7, 8'd4 ^ SX);
    run_xfer(8'h00, 1);

    wr_reg(3'd6, 8'd0 ^ SX);
    run_zero(8'h00);

    reset_mid();
    wr_reg(3'd6, 8'd2 ^ SX);
    wr_reg(3'd7, 8'd1 ^ SX);
    run_xfer(8'h10, 0);
    chk("rst_const", 32'(wlog[0]), 32'hFF);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) != 0) wr_reg(3'd1, 8'($urandom));
      for (int r = 2; r < 6; r++)
        if ($urandom_range(0, 3) != 0)
          wr_reg(3'(r), (r[0] == 1'b0 && $urandom_range(0, 3) == 0) ?
                 8'hFF : 8'($urandom));
      ws = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
      hs = $urandom_range(1, 4);
      if ($urandom_range(0, 3) != 0) wr_reg(3'd6, 8'(ws) ^ SX);
      if ($urandom_range(0, 3) != 0) wr_reg(3'd7, 8'(hs) ^ SX);
      ctrl = 8'($urandom);
      es_per = (ctrl[2] && $urandom_range(0, 1) == 1) ?
               $urandom_range(2, 5) : 0;
      if (sh_w == 0 || sh_h == 0) run_zero(ctrl);
      else run_xfer(ctrl, 1);
      es_per = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
